pixel_dispatcher: RTL

Frame-level initiator for the Mandelbrot depth calculator. Scans an H_RES × V_RES pixel grid and derives each pixel's complex coordinate (re_c, im_c) incrementally from a latched viewport (re_min, im_max, step). Issues one `start` per pixel, holds all calculator operands stable until `calc_done`, and emits each depth on a valid/ready pixel stream with line and frame markers. Sits between the PYNQ control registers and the depth calculator on one side, and the frame buffer/video path on the other.

---
 rtl/mandelbrot_pkg.sv | 15 +
 rtl/pixel_dispatcher_coord.sv | 57 +++++
 rtl/pixel_dispatcher.sv | 116 +++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot depth calculator and its pixel dispatcher.
package mandelbrot_pkg;
  localparam int unsigned WORD_LENGTH = 32;
  localparam int unsigned FRAC        = 28;
  localparam int unsigned H_RES       = 640;
  localparam int unsigned V_RES       = 480;

  typedef logic signed [WORD_LENGTH-1:0] fixed_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } disp_state_t;
endpackage

// File: rtl/pixel_dispatcher_coord.sv
// Pixel grid walker: x/y counters with incrementally stepped complex coordinate.
module coord_stepper
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = mandelbrot_pkg::WORD_LENGTH,
  parameter int unsigned H_RES       = mandelbrot_pkg::H_RES,
  parameter int unsigned V_RES       = mandelbrot_pkg::V_RES
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          advance,
  input  logic signed [WORD_LENGTH-1:0] re_min,
  input  logic signed [WORD_LENGTH-1:0] im_max,
  input  logic signed [WORD_LENGTH-1:0] step,
  output logic        [9:0]             x,
  output logic        [8:0]             y,
  output logic signed [WORD_LENGTH-1:0] re_c,
  output logic signed [WORD_LENGTH-1:0] im_c,
  output logic                          is_last
);
  logic signed [WORD_LENGTH-1:0] re_min_q;
  logic signed [WORD_LENGTH-1:0] step_q;
  logic                          x_end;

  assign x_end   = (x == 10'(H_RES - 1));
  assign is_last = x_end && (y == 9'(V_RES - 1));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      re_min_q <= '0;
      step_q   <= '0;
      x        <= '0;
      y        <= '0;
      re_c     <= '0;
      im_c     <= '0;
    end else if (load) begin
      re_min_q <= re_min;
      step_q   <= step;
      x        <= '0;
      y        <= '0;
      re_c     <= re_min;
      im_c     <= im_max;
    end else if (advance) begin
      if (x_end) begin
        // Row wrap restarts re from the latched origin, avoiding accumulated drift.
        x    <= '0;
        y    <= y + 9'd1;
        re_c <= re_min_q;
        im_c <= im_c - step_q;
      end else begin
        x    <= x + 10'd1;
        re_c <= re_c + step_q;
      end
    end
  end
endmodule

// File: rtl/pixel_dispatcher.sv
// Frame-level initiator: issues one calculator start per pixel and streams depths out.
module pixel_dispatcher
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = mandelbrot_pkg::WORD_LENGTH,
  parameter int unsigned H_RES       = mandelbrot_pkg::H_RES,
  parameter int unsigned V_RES       = mandelbrot_pkg::V_RES
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic signed [WORD_LENGTH-1:0] re_min_in,
  input  logic signed [WORD_LENGTH-1:0] im_max_in,
  input  logic signed [WORD_LENGTH-1:0] step_in,
  input  logic        [9:0]             max_iter_in,
  output logic                          start,
  output logic        [9:0]             x,
  output logic        [8:0]             y,
  output logic signed [WORD_LENGTH-1:0] re_c,
  output logic signed [WORD_LENGTH-1:0] im_c,
  output logic        [9:0]             max_iter,
  input  logic        [9:0]             calc_depth,
  input  logic                          calc_done,
  output logic        [9:0]             px_data,
  output logic                          px_valid,
  input  logic                          px_ready,
  output logic                          px_last,
  output logic                          px_user,
  output logic                          busy,
  output logic                          frame_done
);
  disp_state_t state, state_nx;
  logic        load;
  logic        store;
  logic        advance;
  logic        is_last;

  coord_stepper #(
    .WORD_LENGTH (WORD_LENGTH),
    .H_RES       (H_RES),
    .V_RES       (V_RES)
  ) u_coord (
    .sysclk  (sysclk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .re_min  (re_min_in),
    .im_max  (im_max_in),
    .step    (step_in),
    .x       (x),
    .y       (y),
    .re_c    (re_c),
    .im_c    (im_c),
    .is_last (is_last)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // calc_done is only looked at in WAIT, so a level left over from the
  // previous pixel during the ISSUE cycle can never be mistaken for a result.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    store    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_start) begin
          load     = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (calc_done && (!px_valid || px_ready)) begin
          store    = 1'b1;
          state_nx = is_last ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign start   = (state == ST_ISSUE);
  assign advance = store && !is_last;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      px_data    <= '0;
      px_valid   <= 1'b0;
      px_last    <= 1'b0;
      px_user    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      max_iter   <= '0;
    end else begin
      frame_done <= store && is_last;
      if (load) begin
        max_iter <= max_iter_in;
        busy     <= 1'b1;
      end else if (store && is_last) begin
        busy <= 1'b0;
      end
      if (store) begin
        px_data  <= calc_depth;
        px_last  <= (x == 10'(H_RES - 1));
        px_user  <= (x == '0) && (y == '0);
        px_valid <= 1'b1;
      end else if (px_ready) begin
        px_valid <= 1'b0;
      end
    end
  end
endmodule
